// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the writeback scheduler.
package wb_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular write-back queue: two pushes per cycle (port a is older), one pop,
// and an age-ordered view of the contents for the pending-mask and forward scans.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_a,
  input  wb_entry_t              entry_a,
  input  logic                   push_b,
  input  wb_entry_t              entry_b,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t              ordered [DEPTH],
  output logic [DEPTH-1:0]       ordered_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  tail_b;

  // The b entry lands behind a whenever both push in the same cycle
  assign tail_b = push_a ? tail + 1'b1 : tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + 1'b1;
      tail  <= tail + PW'(push_a) + PW'(push_b);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) mem[tail]   <= entry_a;
    if (push_b) mem[tail_b] <= entry_b;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ordered[k]       = mem[head + PW'(k)];
      ordered_valid[k] = (CW'(k) < count);
    end
  end
endmodule

// File: rtl/writeback_scheduler.sv
// Register-file write-back scheduler: queues Mem/ALU results in order and issues one write per cycle.
// Optional macro WB_FORWARD_EN adds a combinational forwarding lookup (FwdAddr/FwdHit/FwdData).
module writeback_scheduler
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W,
  parameter int DATA_W     = wb_pkg::DATA_W
) (
  input  logic                         ClockInput,
  input  logic                         ResetInput,
  input  logic                         MemValid,
  input  logic [REG_ADDR_W-1:0]        MemDest,
  input  logic [DATA_W-1:0]            MemData,
  output logic                         MemReady,
  input  logic                         AluValid,
  input  logic [REG_ADDR_W-1:0]        AluDest,
  input  logic [DATA_W-1:0]            AluData,
  output logic                         AluReady,
  output logic [REG_ADDR_W-1:0]        Rwrite,
  output logic                         WriteRegSignal,
  output logic [DATA_W-1:0]            WriteData,
  output logic [(1<<REG_ADDR_W)-1:0]   PendingMask,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         Idle
`ifdef WB_FORWARD_EN
  ,
  input  logic [REG_ADDR_W-1:0]        FwdAddr,
  output logic                         FwdHit,
  output logic [DATA_W-1:0]            FwdData
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pop;
  logic [CW:0]     free_slots;
  logic            mem_take;
  logic            alu_take;
  wb_entry_t       mem_entry;
  wb_entry_t       alu_entry;
  wb_entry_t       ordered [DEPTH];
  logic [DEPTH-1:0] ordered_valid;

  // Free slots include the entry leaving for the output stage this same edge
  assign pop        = (Count != '0);
  assign free_slots = (CW+1)'(DEPTH) - {1'b0, Count} + {{CW{1'b0}}, pop};
  assign MemReady   = (free_slots != '0);
  assign AluReady   = MemValid ? (free_slots >= (CW+1)'(2)) : (free_slots != '0);
  assign mem_take   = MemValid & MemReady;
  assign alu_take   = AluValid & AluReady;
  assign mem_entry  = {MemDest, MemData};
  assign alu_entry  = {AluDest, AluData};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (ClockInput),
    .rst           (ResetInput),
    .push_a        (mem_take),
    .entry_a       (mem_entry),
    .push_b        (alu_take),
    .entry_b       (alu_entry),
    .pop           (pop),
    .count         (Count),
    .ordered       (ordered),
    .ordered_valid (ordered_valid)
  );

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      WriteRegSignal <= 1'b0;
      Rwrite         <= '0;
      WriteData      <= '0;
    end else if (pop) begin
      WriteRegSignal <= 1'b1;
      Rwrite         <= ordered[0].dest;
      WriteData      <= ordered[0].data;
    end else begin
      WriteRegSignal <= 1'b0;
    end
  end

  always_comb begin
    PendingMask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (ordered_valid[k]) PendingMask[ordered[k].dest] = 1'b1;
    if (WriteRegSignal) PendingMask[Rwrite] = 1'b1;
  end

  assign Idle = (Count == '0) && !WriteRegSignal;

`ifdef WB_FORWARD_EN
  // Later (younger) queue matches override the output stage and older entries
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    if (WriteRegSignal && (Rwrite == FwdAddr)) begin
      FwdHit  = 1'b1;
      FwdData = WriteData;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ordered_valid[k] && (ordered[k].dest == FwdAddr)) begin
        FwdHit  = 1'b1;
        FwdData = ordered[k].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_writeback_scheduler.sv
// Bench for writeback_scheduler: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_writeback_scheduler;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemValid, AluValid;
  logic [3:0]  MemDest, AluDest;
  logic [31:0] MemData, AluData;
  logic        MemReady, AluReady;
  logic [3:0]  Rwrite;
  logic        WriteRegSignal;
  logic [31:0] WriteData;
  logic [15:0] PendingMask;
  logic [2:0]  Count;
  logic        Idle;
  logic [3:0]  FwdAddr;
`ifdef WB_FORWARD_EN
  logic        FwdHit;
  logic [31:0] FwdData;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  writeback_scheduler #(.DEPTH(DEPTH)) dut (
    .ClockInput     (clk),
    .ResetInput     (rst),
    .MemValid       (MemValid),
    .MemDest        (MemDest),
    .MemData        (MemData),
    .MemReady       (MemReady),
    .AluValid       (AluValid),
    .AluDest        (AluDest),
    .AluData        (AluData),
    .AluReady       (AluReady),
    .Rwrite         (Rwrite),
    .WriteRegSignal (WriteRegSignal),
    .WriteData      (WriteData),
    .PendingMask    (PendingMask),
    .Count          (Count),
    .Idle           (Idle)
`ifdef WB_FORWARD_EN
    ,
    .FwdAddr        (FwdAddr),
    .FwdHit         (FwdHit),
    .FwdData        (FwdData)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of queued writes in arrival order plus the presented write
  wb_entry_t   mq[$];
  bit          m_wrs  = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          u_n, u_free;
  bit          u_mt, u_at;
  wb_entry_t   u_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_wrs  = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      u_n    = mq.size();
      u_free = DEPTH - u_n + ((u_n > 0) ? 1 : 0);
      u_mt   = MemValid && (u_free >= 1);
      u_at   = AluValid && (u_free >= (MemValid ? 2 : 1));
      if (u_n > 0) begin
        u_e    = mq.pop_front();
        m_wrs  = 1'b1;
        m_addr = u_e.dest;
        m_data = u_e.data;
      end else begin
        m_wrs = 1'b0;
      end
      if (u_mt) mq.push_back({MemDest, MemData});
      if (u_at) mq.push_back({AluDest, AluData});
    end
  end

  int          c_n, c_free;
  logic [15:0] c_mask;
  bit          c_hit;
  logic [31:0] c_fdata;

  always @(negedge clk) begin
    if (cmp_en) begin
      c_n    = mq.size();
      c_free = DEPTH - c_n + ((c_n > 0) ? 1 : 0);
      c_mask = '0;
      foreach (mq[i]) c_mask[mq[i].dest] = 1'b1;
      if (m_wrs) c_mask[m_addr] = 1'b1;
      chk("Count", Count, c_n);
      chk("WriteRegSignal", WriteRegSignal, m_wrs);
      chk("Rwrite", Rwrite, m_addr);
      chk("WriteData", WriteData, m_data);
      chk("PendingMask", PendingMask, c_mask);
      chk("MemReady", MemReady, c_free >= 1);
      chk("AluReady", AluReady, c_free >= (MemValid ? 2 : 1));
      chk("Idle", Idle, (c_n == 0) && !m_wrs);
`ifdef WB_FORWARD_EN
      c_hit = 1'b0;
      c_fdata = '0;
      for (int i = c_n - 1; i >= 0; i--) begin
        if (mq[i].dest == FwdAddr) begin
          c_hit = 1'b1;
          c_fdata = mq[i].data;
          break;
        end
      end
      if (!c_hit && m_wrs && m_addr == FwdAddr) begin
        c_hit = 1'b1;
        c_fdata = m_data;
      end
      chk("FwdHit", FwdHit, c_hit);
      chk("FwdData", FwdData, c_fdata);
`endif
    end
  end

  task automatic step(input bit mv, input logic [3:0] md, input logic [31:0] mdat,
                      input bit av, input logic [3:0] ad, input logic [31:0] adat);
    MemValid = mv; MemDest = md; MemData = mdat;
    AluValid = av; AluDest = ad; AluData = adat;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_step();
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while (!Idle && guard < 20) begin
      idle_step();
      guard++;
    end
    chk(nm, Idle, 1'b1);
  endtask

  int exp_cnt[5] = '{2, 3, 4, 4, 4};

  initial begin
    MemValid = 0; MemDest = 0; MemData = 0;
    AluValid = 0; AluDest = 0; AluData = 0;
    FwdAddr  = 0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_count", Count, 0);
    chk("rst_wrs", WriteRegSignal, 0);
    chk("rst_rwrite", Rwrite, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_mask", PendingMask, 0);
    chk("rst_idle", Idle, 1);

    // Single ALU write: accepted at edge 1, presented after edge 2, gone after edge 3
    step(0, 0, 0, 1, 4'd3, 32'h1234);
    chk("t1_count", Count, 1);
    chk("t1_mask_e1", PendingMask[3], 1);
    chk("t1_wrs_e1", WriteRegSignal, 0);
    idle_step();
    chk("t1_wrs_e2", WriteRegSignal, 1);
    chk("t1_rwrite", Rwrite, 3);
    chk("t1_wdata", WriteData, 32'h1234);
    chk("t1_mask_e2", PendingMask, 16'h0008);
    idle_step();
    chk("t1_wrs_e3", WriteRegSignal, 0);
    chk("t1_mask_e3", PendingMask, 0);
    chk("t1_idle", Idle, 1);

    // Mem and ALU together: Mem is older
    step(1, 4'd2, 32'd7, 1, 4'd1, 32'd5);
    chk("t2_count", Count, 2);
    idle_step();
    chk("t2_rw0", Rwrite, 2);
    chk("t2_wd0", WriteData, 7);
    idle_step();
    chk("t2_wrs1", WriteRegSignal, 1);
    chk("t2_rw1", Rwrite, 1);
    chk("t2_wd1", WriteData, 5);
    drain("t2_idle");

    // Both sources every cycle until the queue saturates
    for (int i = 0; i < 5; i++) begin
      MemValid = 1; MemDest = 4'(i);     MemData = 32'(100 + i);
      AluValid = 1; AluDest = 4'(i + 8); AluData = 32'(200 + i);
      #1;
      if (i >= 3) begin
        chk("t3_alurdy_full", AluReady, 0);
        chk("t3_memrdy_full", MemReady, 1);
      end
      @(posedge clk);
      #2;
      chk("t3_count", Count, exp_cnt[i]);
    end
    drain("t3_idle");

    // Same destination twice: older value lands first, mask holds until the last
    step(1, 4'd5, 32'd1, 1, 4'd5, 32'd2);
    chk("t4_mask_q", PendingMask[5], 1);
    idle_step();
    chk("t4_wd0", WriteData, 1);
    chk("t4_mask0", PendingMask[5], 1);
    idle_step();
    chk("t4_wd1", WriteData, 2);
    chk("t4_rw1", Rwrite, 5);
    chk("t4_mask1", PendingMask[5], 1);
    idle_step();
    chk("t4_mask_clr", PendingMask[5], 0);

    // Reset between edges with three queued entries
    step(1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
    step(1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
    MemValid = 0; AluValid = 0;
    chk("t5_count_pre", Count, 3);
    #1 rst = 1'b1;
    #1;
    chk("t5_wrs", WriteRegSignal, 0);
    chk("t5_count", Count, 0);
    chk("t5_mask", PendingMask, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      chk("t5_nowrite", WriteRegSignal, 0);
    end

`ifdef WB_FORWARD_EN
    step(1, 4'd4, 32'hA, 1, 4'd4, 32'hB);
    MemValid = 0; AluValid = 0;
    FwdAddr = 4'd4;
    #1;
    chk("t6_hit4", FwdHit, 1);
    chk("t6_data4", FwdData, 32'hB);
    FwdAddr = 4'd6;
    #1;
    chk("t6_hit6", FwdHit, 0);
    chk("t6_data6", FwdData, 0);
    drain("t6_idle");
`endif

    // Random traffic, with bursts that push the queue to full
    for (int i = 0; i < 400; i++) begin
      FwdAddr = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom);
    end
    drain("rand_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule
